// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator with frame-synchronous output mode select.
// Counters, sample window, pixel request and registered DAC/sync outputs.
module vga_timing_gen_param #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned IN_W     = 10,
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned REQ_LEAD = 2
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [1:0]       iMODE,
    input  logic [IN_W-1:0]  iRed,
    input  logic [IN_W-1:0]  iGreen,
    input  logic [IN_W-1:0]  iBlue,
    output logic             oRequest,
    output logic [9:0]       DrawX,
    output logic [9:0]       DrawY,
    output logic [OUT_W-1:0] oVGA_R,
    output logic [OUT_W-1:0] oVGA_G,
    output logic [OUT_W-1:0] oVGA_B,
    output logic             oVGA_H_SYNC,
    output logic             oVGA_V_SYNC,
    output logic             oVGA_BLANK,
    output logic             oVGA_SYNC,
    output logic             oVGA_CLOCK,
    output logic             oFrameStart,
    output logic             oLineStart
);

    localparam int H_TOTAL  = int'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam int HA_START = int'(H_SYNC + H_BP);
    localparam int HA_END   = HA_START + int'(H_ACTIVE);
    localparam int V_TOTAL  = int'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam int VA_START = int'(V_SYNC + V_BP);
    localparam int VA_END   = VA_START + int'(V_ACTIVE);
    localparam int RQ_START = HA_START - int'(REQ_LEAD);
    localparam int RQ_END   = HA_END - int'(REQ_LEAD);
    localparam int BAR_W    = int'(H_ACTIVE / 8);
    localparam int HCW      = $clog2(H_TOTAL);
    localparam int VCW      = $clog2(V_TOTAL);
    localparam int BPW      = $clog2(BAR_W + 1);
    localparam int LSH      = int'(IN_W) + 2 - int'(OUT_W);

    typedef enum logic [1:0] {
        ModePass  = 2'b00,
        ModeGray  = 2'b01,
        ModeBars  = 2'b10,
        ModeBlack = 2'b11
    } mode_e;

    logic [HCW-1:0]   h_cnt_q, h_cnt_d;
    logic [VCW-1:0]   v_cnt_q, v_cnt_d;
    logic [2:0]       bar_q, bar_d;
    logic [BPW-1:0]   px_q, px_d;
    mode_e            mode_q, mode_d;
    logic             req_q, req_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             blank_q, fs_q, fs_d, ls_q, ls_d;
    logic [OUT_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    logic             h_wrap, v_wrap, h_act, v_act, s_win;
    logic             h_req_d, v_act_d;
    logic [IN_W+1:0]  luma_sum;
    logic [OUT_W-1:0] luma;

    always_comb begin
        h_wrap  = (int'(h_cnt_q) == H_TOTAL - 1);
        v_wrap  = (int'(v_cnt_q) == V_TOTAL - 1);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_comb begin
        h_act   = (int'(h_cnt_q) >= HA_START) && (int'(h_cnt_q) < HA_END);
        v_act   = (int'(v_cnt_q) >= VA_START) && (int'(v_cnt_q) < VA_END);
        s_win   = h_act && v_act;
        DrawX   = s_win ? 10'(h_cnt_q - HCW'(HA_START)) : '0;
        DrawY   = s_win ? 10'(v_cnt_q - VCW'(VA_START)) : '0;
        // Request is registered, so it is decoded from the counter value of the next cycle.
        h_req_d = (int'(h_cnt_d) >= RQ_START) && (int'(h_cnt_d) < RQ_END);
        v_act_d = (int'(v_cnt_d) >= VA_START) && (int'(v_cnt_d) < VA_END);
        req_d   = h_req_d && v_act_d;
    end

    // Bar index tracks the current h_cnt; bar 7 never advances so it soaks up the remainder.
    always_comb begin
        bar_d = bar_q;
        px_d  = px_q;
        if (int'(h_cnt_d) == HA_START) begin
            bar_d = '0;
            px_d  = '0;
        end else if (h_act && (bar_q != 3'd7)) begin
            if (int'(px_q) == BAR_W - 1) begin
                bar_d = bar_q + 3'd1;
                px_d  = '0;
            end else begin
                px_d = px_q + 1'b1;
            end
        end
    end

    assign luma_sum = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};
    assign luma     = OUT_W'(luma_sum >> LSH);

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (s_win) begin
            unique case (mode_q)
                ModePass: begin
                    r_d = iRed[IN_W-1 -: OUT_W];
                    g_d = iGreen[IN_W-1 -: OUT_W];
                    b_d = iBlue[IN_W-1 -: OUT_W];
                end
                ModeGray: begin
                    r_d = luma;
                    g_d = luma;
                    b_d = luma;
                end
                ModeBars: begin
                    r_d = {OUT_W{~bar_q[2]}};
                    g_d = {OUT_W{~bar_q[1]}};
                    b_d = {OUT_W{~bar_q[0]}};
                end
                ModeBlack: begin
                    r_d = '0;
                    g_d = '0;
                    b_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        hs_d   = (int'(h_cnt_q) < int'(H_SYNC)) ? HS_POL : ~HS_POL;
        vs_d   = (int'(v_cnt_q) < int'(V_SYNC)) ? VS_POL : ~VS_POL;
        ls_d   = (h_cnt_q == '0);
        fs_d   = ls_d && (v_cnt_q == '0);
        mode_d = (h_wrap && v_wrap) ? mode_e'(iMODE) : mode_q;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            bar_q   <= '0;
            px_q    <= '0;
            mode_q  <= ModePass;
            req_q   <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            bar_q   <= bar_d;
            px_q    <= px_d;
            mode_q  <= mode_d;
            req_q   <= req_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= s_win;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign oRequest    = req_q;
    assign oVGA_R      = r_q;
    assign oVGA_G      = g_q;
    assign oVGA_B      = b_q;
    assign oVGA_H_SYNC = hs_q;
    assign oVGA_V_SYNC = vs_q;
    assign oVGA_BLANK  = blank_q;
    assign oVGA_SYNC   = 1'b0;
    assign oVGA_CLOCK  = iCLK;
    assign oFrameStart = fs_q;
    assign oLineStart  = ls_q;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Directed bench: default horizontal timing (A) and a narrow HS_POL=1 variant (B),
// both with a short vertical frame so several frames fit in the run.
module tb_vga_timing_gen_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [9:0] r_in = 10'h3FF;
    logic [9:0] g_in = 10'h200;
    logic [9:0] b_in = 10'h004;

    logic       a_req, a_hs, a_vs, a_blank, a_sync, a_clock, a_fs, a_ls;
    logic [9:0] a_x, a_y;
    logic [7:0] a_r, a_g, a_b;
    logic       b_req, b_hs, b_vs, b_blank, b_sync, b_clock, b_fs, b_ls;
    logic [9:0] b_x, b_y;
    logic [7:0] b_r, b_g, b_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen_param #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_dut_a (
        .iCLK(clk), .iRST_N(rst_n), .iMODE(mode),
        .iRed(r_in), .iGreen(g_in), .iBlue(b_in),
        .oRequest(a_req), .DrawX(a_x), .DrawY(a_y),
        .oVGA_R(a_r), .oVGA_G(a_g), .oVGA_B(a_b),
        .oVGA_H_SYNC(a_hs), .oVGA_V_SYNC(a_vs), .oVGA_BLANK(a_blank),
        .oVGA_SYNC(a_sync), .oVGA_CLOCK(a_clock),
        .oFrameStart(a_fs), .oLineStart(a_ls)
    );

    vga_timing_gen_param #(
        .H_ACTIVE(320), .H_FP(8), .H_SYNC(48), .H_BP(24), .HS_POL(1'b1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_dut_b (
        .iCLK(clk), .iRST_N(rst_n), .iMODE(mode),
        .iRed(r_in), .iGreen(g_in), .iBlue(b_in),
        .oRequest(b_req), .DrawX(b_x), .DrawY(b_y),
        .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b),
        .oVGA_H_SYNC(b_hs), .oVGA_V_SYNC(b_vs), .oVGA_BLANK(b_blank),
        .oVGA_SYNC(b_sync), .oVGA_CLOCK(b_clock),
        .oFrameStart(b_fs), .oLineStart(b_ls)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic reset_checks(input string pfx);
        check({pfx, " a_req"}, int'(a_req), 0);
        check({pfx, " a_blank"}, int'(a_blank), 0);
        check({pfx, " a_fs"}, int'(a_fs), 0);
        check({pfx, " a_ls"}, int'(a_ls), 0);
        check({pfx, " a_rgb"}, int'({a_r, a_g, a_b}), 0);
        check({pfx, " a_hs"}, int'(a_hs), 1);
        check({pfx, " a_vs"}, int'(a_vs), 1);
        check({pfx, " a_xy"}, int'({a_x, a_y}), 0);
        check({pfx, " a_sync"}, int'(a_sync), 0);
        check({pfx, " b_hs"}, int'(b_hs), 0);
        check({pfx, " b_vs"}, int'(b_vs), 1);
        check({pfx, " b_blank"}, int'(b_blank), 0);
    endtask

    // One A frame is 800 x 9 = 7200 clocks (two B frames). Sample c reflects h_cnt = c in
    // the registered outputs; the combinational DrawX/DrawY and oRequest reflect c+1.
    task automatic run_frame(input int em, input int chg_at, input int chg_mode,
                             input int abort_at);
        int xs   [7] = '{0, 79, 80, 159, 320, 559, 639};
        int bars [7] = '{32'hFFFFFF, 32'hFFFFFF, 32'hFFFF00, 32'hFFFF00,
                         32'h00FFFF, 32'h0000FF, 32'h000000};
        int hs_low = 0, vs_low = 0, fs_n = 0, ls_n = 0, req_n = 0, blk_n = 0;
        int req_first = -1, blk_first = -1, max_x = 0, max_y = 0, bad_col = 0;
        int fall0 = -1, fall1 = -1, hsb_high = 0, blkb_n = 0, cb, expc;
        logic prev_hs;
        prev_hs = a_hs;
        for (int c = 0; c < 7200; c++) begin
            @(posedge clk);
            #1;
            cb = c % 3600;
            if (!a_hs) hs_low++;
            if (prev_hs && !a_hs) begin
                if (fall0 < 0) fall0 = c;
                else if (fall1 < 0) fall1 = c;
            end
            prev_hs = a_hs;
            if (!a_vs) vs_low++;
            if (a_fs) fs_n++;
            if (a_ls) ls_n++;
            if (a_req) begin
                req_n++;
                if (req_first < 0) req_first = c;
            end
            if (a_blank) begin
                blk_n++;
                if (blk_first < 0) blk_first = c;
            end
            if (int'(a_x) > max_x) max_x = int'(a_x);
            if (int'(a_y) > max_y) max_y = int'(a_y);
            if (!a_blank && ({a_r, a_g, a_b} != 24'h0)) bad_col++;
            if (b_hs) hsb_high++;
            if (b_blank) blkb_n++;

            case (c)
                0: begin
                    check("fs at frame start", int'(a_fs), 1);
                    check("ls at frame start", int'(a_ls), 1);
                    check("hs asserted at 0", int'(a_hs), 0);
                    check("vs asserted at 0", int'(a_vs), 0);
                end
                800:  check("ls at line 1", int'(a_ls), 1);
                1599: check("vs last low", int'(a_vs), 0);
                1600: check("vs released", int'(a_vs), 1);
                3340: check("req before lead", int'(a_req), 0);
                3341: check("req at h142", int'(a_req), 1);
                3343: begin
                    check("blank at h143", int'(a_blank), 0);
                    check("drawx first", int'(a_x), 0);
                end
                3982: check("drawx last", int'(a_x), 639);
                5743: check("drawy row 3", int'(a_y), 3);
                4299: check("blank mid row5", int'(a_blank), 1);
                default: ;
            endcase

            for (int k = 0; k < 7; k++) begin
                if (c == 3344 + xs[k]) begin
                    case (em)
                        0:       expc = 32'hFF8001;
                        1:       expc = 32'h808080;
                        2:       expc = bars[k];
                        default: expc = 0;
                    endcase
                    check($sformatf("rgb mode%0d x%0d", em, xs[k]), int'({a_r, a_g, a_b}), expc);
                end
            end

            if (c < 3600) begin
                case (cb)
                    0:    check("b hs at 0", int'(b_hs), 1);
                    47:   check("b hs at 47", int'(b_hs), 1);
                    48:   check("b hs at 48", int'(b_hs), 0);
                    400:  check("b hs period", int'(b_hs), 1);
                    1671: check("b blank pre", int'(b_blank), 0);
                    1672: begin
                        check("b blank first", int'(b_blank), 1);
                        if (em == 0) check("b rgb pass", int'({b_r, b_g, b_b}), 32'hFF8001);
                    end
                    1991: check("b blank last", int'(b_blank), 1);
                    1992: check("b blank post", int'(b_blank), 0);
                    default: ;
                endcase
            end

            if (c == chg_at) mode = 2'(chg_mode);
            if (c == abort_at) begin
                rst_n = 1'b0;
                return;
            end
        end
        check("hs low clocks", hs_low, 864);
        check("hs first fall", fall0, 0);
        check("hs period", fall1 - fall0, 800);
        check("vs low clocks", vs_low, 1600);
        check("fs per frame", fs_n, 1);
        check("ls per frame", ls_n, 9);
        check("req clocks", req_n, 2560);
        check("req first", req_first, 3341);
        check("blank clocks", blk_n, 2560);
        check("blank first", blk_first, 3344);
        check("drawx max", max_x, 639);
        check("drawy max", max_y, 3);
        check("colour in porch", bad_col, 0);
        check("b hs high clocks", hsb_high, 864);
        check("b blank clocks", blkb_n, 2560);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 1000, 1, -1);
        run_frame(1, 1000, 2, -1);
        run_frame(2, 3600, 3, -1);
        run_frame(3, 1000, 0, -1);
        run_frame(0, -1, 0, 4299);
        @(posedge clk);
        #1;
        reset_checks("rst1");
        mode = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, -1, 0, -1);
        run_frame(3, -1, 0, -1);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen_param.md
Name: vga_timing_gen_param

Overview:
Parametrised VGA timing and pixel-output generator. It is the successor to the fixed 640x480 controller and sits between the frame buffer / camera pixel path and the VGA DAC. Porch, sync and active timings, sync polarity, colour widths and request lead are all generics. It adds a frame-synchronous output mode select (pass-through, luma grayscale, colour-bar test pattern, forced black) and frame/line start strobes.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, asserted level of oVGA_H_SYNC
VS_POL, 0, asserted level of oVGA_V_SYNC
IN_W, 10, host colour width; IN_W >= OUT_W is required
OUT_W, 8, DAC colour width
REQ_LEAD, 2, cycles oRequest leads the pixel sample window (0..H_BP)

Ports:
iCLK  in  1  pixel clock
iRST_N  in  1  synchronous active-low reset
iMODE  in  2  00 pass, 01 gray, 10 colour bars, 11 black
iRed  in  IN_W  host red
iGreen  in  IN_W  host green
iBlue  in  IN_W  host blue
oRequest  out  1  pixel request to host
DrawX  out  10  active-area column of pixel being sampled
DrawY  out  10  active-area row of pixel being sampled
oVGA_R  out  OUT_W  red to DAC
oVGA_G  out  OUT_W  green to DAC
oVGA_B  out  OUT_W  blue to DAC
oVGA_H_SYNC  out  1  horizontal sync
oVGA_V_SYNC  out  1  vertical sync
oVGA_BLANK  out  1  high during visible pixels, low otherwise
oVGA_SYNC  out  1  tied 0
oVGA_CLOCK  out  1  equals iCLK
oFrameStart  out  1  one-cycle strobe, first clock of a frame
oLineStart  out  1  one-cycle strobe, first clock of each line

Behaviour:
- Derived values: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; HA_START = H_SYNC+H_BP; HA_END = HA_START+H_ACTIVE. The same pattern gives V_TOTAL, VA_START and VA_END.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1. Count 0 is the first clock of the sync pulse.
- Sample window S: HA_START <= h_cnt < HA_END and VA_START <= v_cnt < VA_END.
- In S: DrawX = h_cnt-HA_START and DrawY = v_cnt-VA_START, both combinational. Outside S: both are 0.
- The host must present the pixel for (DrawX, DrawY) on iRed/iGreen/iBlue in the same cycle.
- oRequest is high exactly in cycles where v_cnt is in the active range and HA_START-REQ_LEAD <= h_cnt < HA_END-REQ_LEAD. Implement it registered, comparing against the next counter value.
- Registered outputs, 1-cycle latency relative to the counters. These are: syncs, oVGA_BLANK, colours, oFrameStart, oLineStart.
  - oVGA_H_SYNC = HS_POL when h_cnt < H_SYNC, else ~HS_POL.
  - oVGA_V_SYNC = VS_POL when v_cnt < V_SYNC, else ~VS_POL.
  - oVGA_BLANK = S.
  - oLineStart = (h_cnt == 0).
  - oFrameStart = (h_cnt == 0 && v_cnt == 0).
- Colour outputs are 0 whenever S is false. When S is true, they follow mode_q:
  - 00: top OUT_W bits of each input.
  - 01: Y = (R + 2G + B) >> 2, computed in IN_W+2 bits, no overflow. All three outputs = top OUT_W bits of Y.
  - 10: 8 equal vertical bars with bar index b = DrawX / (H_ACTIVE/8). Use an incrementing bar counter, not a divider. Bar counter resets at HA_START; the last bar absorbs any remainder. Each channel is all-ones or 0: R = ~b[2], G = ~b[1], B = ~b[0], so bar 0 is white and bar 7 is black. Host inputs are ignored.
  - 11: all zeros.
- mode_q loads iMODE only on the clock where h_cnt == H_TOTAL-1 and v_cnt == V_TOTAL-1. A mid-frame iMODE change never tears a frame.
- Reset (iRST_N low at a clock edge), from any state including mid-line or mid-frame:
  - h_cnt, v_cnt, mode_q and bar counter go to 0.
  - oRequest, oVGA_BLANK, oFrameStart, oLineStart and all colours go to 0.
  - Syncs go to their deasserted levels (~HS_POL, ~VS_POL).
  - On the first clock with iRST_N high, counting starts at h_cnt = 0, v_cnt = 0. oFrameStart pulses on the following clock.
- DrawX/DrawY are 10-bit; H_ACTIVE and V_ACTIVE must be <= 1024. Counters are sized $clog2(TOTAL).

Test Plan:
- Default params, release reset: oVGA_H_SYNC period 800 clocks, low 96; oVGA_V_SYNC period 420000 clocks, low 1600; oFrameStart once per 420000; oLineStart every 800.
- Default params, line in active rows: oRequest high 640 clocks starting at h_cnt = 142. oVGA_BLANK high 640 clocks starting one clock after h_cnt = 144. DrawX runs 0..639.
- Mode 00 with iRed = 10'h3FF, iGreen = 10'h200, iBlue = 10'h004 → oVGA_R = 8'hFF, oVGA_G = 8'h80, oVGA_B = 8'h01. Outputs are 0 in porches.
- Mode 01, same inputs → Y = (1023 + 1024 + 4) >> 2 = 512, so all channels = 8'h80. Mode 10 → DrawX 0..79 white FF/FF/FF; DrawX 80..159 FF/FF/00; DrawX 560..639 all 00.
- iMODE switched 00→11 mid-frame → current frame stays pass-through; next frame, after oFrameStart, is all zero.
- Reset asserted at h_cnt = 300, v_cnt = 200 → next clock: all outputs at reset values, syncs inactive. After release, the full frame timing is identical to the first test.
- HS_POL = 1, H_ACTIVE = 320, H_FP = 8, H_SYNC = 48, H_BP = 24 → H period 400, sync high 48 clocks, 320 visible clocks.
